// File: rtl/display_sum_seq.sv
// Adds or subtracts two unsigned operands, then converts the magnitude to BCD one bit per cycle.
// Drives an active-low 7-segment display with sign, overflow dashes and optional leading-zero blanking.
module display_sum_seq #(
  parameter int N        = 5,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [N-1:0]          A,
  input  logic [N-1:0]          B,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);
  localparam int BD = (N + 3) / 3 + 1;
  localparam int BW = 4 * BD;
  localparam int PD = (BD > DIGITS) ? BD : DIGITS;
  localparam int PW = 4 * PD;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [N:0]          r_bin;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_sign;
  logic [N:0]          w_mag;
  logic                w_sign;
  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_bcd_nxt;
  logic [N:0]          w_bin_nxt;
  logic [PW-1:0]       w_bcd_pad;
  logic [7*DIGITS-1:0] w_seg_nxt;
  logic                w_ovf_nxt;
  logic                w_lz;
  logic [3:0]          w_dig;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  always_comb begin
    w_sign = 1'b0;
    if (!op) begin
      w_mag = {1'b0, A} + {1'b0, B};
    end else if (A >= B) begin
      w_mag = {1'b0, A - B};
    end else begin
      w_mag  = {1'b0, B - A};
      w_sign = 1'b1;
    end
  end

  // One double-dabble step: adjust every nibble, then shift the binary MSB in.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < BD; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_bcd_nxt = (w_adj << 1) | BW'(r_bin[N]);
  assign w_bin_nxt = r_bin << 1;
  assign w_bcd_pad = PW'(w_bcd_nxt);

  // Display image built from the BCD value the final iteration produces.
  always_comb begin
    w_ovf_nxt = 1'b0;
    w_seg_nxt = '1;
    w_lz      = 1'b1;
    w_dig     = 4'd0;
    for (int i = DIGITS; i < PD; i++) begin
      if (w_bcd_pad[4*i +: 4] != 4'd0) w_ovf_nxt = 1'b1;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_dig = w_bcd_pad[4*i +: 4];
      if (w_dig != 4'd0 || i == 0) w_lz = 1'b0;
      if (w_ovf_nxt)                      w_seg_nxt[7*i +: 7] = 7'h3F;
      else if (BLANK_LZ != 0 && w_lz)     w_seg_nxt[7*i +: 7] = 7'h7F;
      else                                w_seg_nxt[7*i +: 7] = f_seg(w_dig);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CONV;
      CONV:    if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != IDLE);
      done    <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      seg    <= '1;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin  <= w_mag;
            r_sign <= w_sign;
            r_bcd  <= '0;
            r_cnt  <= '0;
          end
        end
        CONV: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            seg <= w_seg_nxt;
            neg <= r_sign;
            ovf <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_display_sum_seq.sv
// Directed and random bench over three parameterisations sharing one stimulus stream,
// with an arithmetic display model feeding per-instance expectation queues.
module tb_display_sum_seq;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;

  logic [13:0] seg0, seg2;
  logic [6:0]  seg1;
  logic neg0, ovf0, busy0, done0;
  logic neg1, ovf1, busy1, done1;
  logic neg2, ovf2, busy2, done2;

  int checks = 0;
  int failures = 0;
  logic [57:0] q0[$];
  logic [57:0] q1[$];
  logic [57:0] q2[$];

  always #5 clk = ~clk;

  display_sum_seq #(.N(N), .DIGITS(2), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .seg(seg0), .neg(neg0), .ovf(ovf0), .busy(busy0), .done(done0));
  display_sum_seq #(.N(N), .DIGITS(1), .BLANK_LZ(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .seg(seg1), .neg(neg1), .ovf(ovf1), .busy(busy1), .done(done1));
  display_sum_seq #(.N(N), .DIGITS(2), .BLANK_LZ(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .seg(seg2), .neg(neg2), .ovf(ovf2), .busy(busy2), .done(done2));

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Returns {ovf, neg, seg[55:0]}; unused upper digits stay all ones.
  function automatic logic [57:0] model(input int a, input int b, input int o,
                                        input int digits, input int blank);
    int v, lim, p;
    logic ng, ov;
    logic [55:0] s;
    ng = 1'b0;
    if (o != 0) begin
      if (a >= b) v = a - b;
      else begin v = b - a; ng = 1'b1; end
    end else begin
      v = a + b;
    end
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ov = (v > lim - 1);
    s = '1;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      if (ov)                                 s[7*i +: 7] = 7'h3F;
      else if (blank != 0 && i > 0 && v < p)  s[7*i +: 7] = 7'h7F;
      else                                    s[7*i +: 7] = enc((v / p) % 10);
      p = p * 10;
    end
    return {ov, ng, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the DUTs idle; returns at the negedge after the sampling edge.
  task automatic do_start(input int a, input int b, input int o);
    A = N'(a);
    B = N'(b);
    op = o[0];
    start = 1'b1;
    q0.push_back(model(a, b, o, 2, 1));
    q1.push_back(model(a, b, o, 1, 1));
    q2.push_back(model(a, b, o, 2, 0));
    @(negedge clk);
    start = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
    op = 1'($urandom);
    check("busy_conv", 64'(busy0), 64'(1));
  endtask

  task automatic wait_done(input string tag, input int cyc0);
    int cyc;
    logic [57:0] e0, e1, e2;
    cyc = cyc0;
    e0 = '1;
    while (done0 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(N + 1));
    if (done0 === 1'b1 && q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      check({tag, "_seg_d2"},  64'(seg0), 64'(e0[13:0]));
      check({tag, "_neg_d2"},  64'(neg0), 64'(e0[56]));
      check({tag, "_ovf_d2"},  64'(ovf0), 64'(e0[57]));
      check({tag, "_seg_d1"},  64'(seg1), 64'(e1[6:0]));
      check({tag, "_neg_d1"},  64'(neg1), 64'(e1[56]));
      check({tag, "_ovf_d1"},  64'(ovf1), 64'(e1[57]));
      check({tag, "_seg_lz0"}, 64'(seg2), 64'(e2[13:0]));
      check({tag, "_neg_lz0"}, 64'(neg2), 64'(e2[56]));
      check({tag, "_done_all"}, 64'({done1, done2, busy0}), 64'(3'b111));
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done0), 64'(0));
    check({tag, "_busy_idle"},  64'(busy0), 64'(0));
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 64'(seg0), 64'(e0[13:0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int da[10] = '{31, 3, 9, 5, 4, 0, 0, 31, 0, 20};
    int db[10] = '{31, 9, 9, 7, 4, 7, 0, 0, 31, 25};
    int dop[10] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    int ndone;

    repeat (2) @(negedge clk);
    check("rst_seg_d2", 64'(seg0), 64'(14'h3FFF));
    check("rst_seg_d1", 64'(seg1), 64'(7'h7F));
    check("rst_flags", 64'({neg0, ovf0, busy0, done0}), 64'(0));

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_start(da[i], db[i], dop[i]);
      wait_done($sformatf("dir%0d", i), 0);
    end

    // Second start two cycles into a conversion must be dropped.
    do_start(12, 13, 0);
    @(negedge clk);
    A = N'(1);
    B = N'(30);
    op = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 2);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0 === 1'b1) ndone++;
    end
    check("ignore_single_done", 64'(ndone), 64'(0));

    // Reset during the third conversion cycle aborts without a done pulse.
    A = N'(17);
    B = N'(6);
    op = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy0), 64'(0));
    check("abort_seg_d2", 64'(seg0), 64'(14'h3FFF));
    check("abort_seg_d1", 64'(seg1), 64'(7'h7F));
    check("abort_flags", 64'({neg0, ovf0, done0}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0 === 1'b1) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'(0));
    check("abort_seg_kept", 64'(seg0), 64'(14'h3FFF));
    do_start(17, 6, 0);
    wait_done("after_abort", 0);

    for (int i = 0; i < 15; i++) begin
      do_start(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
               int'($urandom_range(1, 0)));
      wait_done($sformatf("rnd%0d", i), 0);
    end

    check("queue_empty", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
